// File: rtl/sha_block_fetcher_if.sv
`default_nettype none
// ============================================================================
// Module      : sha_block_fetcher_if
// Description : Bundles the control, BRAM-read and block-handoff signals of
//               the SHA block fetcher.
//               master modport : the fetcher itself
//               slave modport  : the environment (controller, BRAM port,
//                                SHA-256 core)
//   start / base_addr / num_blocks      : fetch request
//   busy / done / error                 : fetch status
//   sha_start_read / sha_bram_addr      : BRAM read request
//   sha_bram_read_data / bram_complete  : BRAM read response
//   block_data / block_valid /
//   block_ready / block_last            : 512-bit block handoff
// Revision    : 1.0 - initial release
// ============================================================================
interface sha_block_fetcher_if;
    logic         start;
    logic [31:0]  base_addr;
    logic [15:0]  num_blocks;
    logic         busy;
    logic         done;
    logic         error;
    logic         sha_start_read;
    logic [31:0]  sha_bram_addr;
    logic [31:0]  sha_bram_read_data;
    logic         bram_complete;
    logic [511:0] block_data;
    logic         block_valid;
    logic         block_ready;
    logic         block_last;

    modport master (
        input  start, base_addr, num_blocks,
        output busy, done, error,
        output sha_start_read, sha_bram_addr,
        input  sha_bram_read_data, bram_complete,
        output block_data, block_valid, block_last,
        input  block_ready
    );

    modport slave (
        output start, base_addr, num_blocks,
        input  busy, done, error,
        input  sha_start_read, sha_bram_addr,
        output sha_bram_read_data, bram_complete,
        input  block_data, block_valid, block_last,
        output block_ready
    );
endinterface
`default_nettype wire

// File: rtl/sha_block_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : sha_block_fetcher
// Description : Reads WORDS_PER_BLOCK consecutive 32-bit words from BRAM per
//               message block (one request per word, sha_start_read /
//               bram_complete handshake), packs them into a 512-bit block
//               (word 0 in the top 32 bits) and hands it to the SHA-256 core
//               over valid/ready. Repeats for num_blocks contiguous blocks,
//               then pulses done. A BRAM response that does not arrive
//               within TIMEOUT_CYCLES aborts the fetch with an error pulse.
// Ports       : axi_clk, axi_rst (sync, active high), bus (master modport)
// Revision    : 1.0 - initial release
// ============================================================================
module sha_block_fetcher #(
    parameter int WORDS_PER_BLOCK = 16,
    parameter int ADDR_STEP       = 4,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  wire logic           axi_clk,
    input  wire logic           axi_rst,
    sha_block_fetcher_if.master bus
);

    localparam int                  c_WC_W      = $clog2(WORDS_PER_BLOCK);
    localparam logic [c_WC_W-1:0]   c_LAST_WORD = c_WC_W'(WORDS_PER_BLOCK - 1);
    localparam logic [7:0]          c_TO_LAST   = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0]         c_ADDR_STEP = 32'(ADDR_STEP);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_READ    = 3'd1,
        S_GAP     = 3'd2,
        S_PRESENT = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [31:0]         r_addr;
    logic [15:0]         r_blk_left;
    logic [c_WC_W-1:0]   r_word_cnt;
    logic [7:0]          r_to_cnt;
    logic [511:0]        r_block;
    logic                r_error;

    logic                w_capture;
    logic                w_timeout;
    logic                w_accept;
    logic [c_WC_W+4:0]   w_slot_lsb;

    // Word 0 lands in the most significant slot, so the slot's LSB counts
    // down from the top as word_cnt counts up.
    assign w_slot_lsb = {c_LAST_WORD - r_word_cnt, 5'b00000};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and event decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_timeout    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_next = (bus.num_blocks == 16'd0) ? S_FINISH : S_READ;
                end
            end
            S_READ: begin
                if (bus.bram_complete) begin
                    w_capture    = 1'b1;
                    w_state_next = (r_word_cnt == c_LAST_WORD) ? S_PRESENT : S_GAP;
                end else if (r_to_cnt == c_TO_LAST) begin
                    // This waiting cycle brings the count to TIMEOUT_CYCLES.
                    w_timeout    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            S_GAP: begin
                // One idle cycle so every word is a distinct request edge.
                w_state_next = S_READ;
            end
            S_PRESENT: begin
                if (bus.block_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = (r_blk_left == 16'd1) ? S_FINISH : S_READ;
                end
            end
            S_FINISH: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_addr     <= 32'd0;
            r_blk_left <= 16'd0;
            r_word_cnt <= '0;
            r_to_cnt   <= 8'd0;
            r_block    <= 512'd0;
            r_error    <= 1'b0;
        end else begin
            r_error <= w_timeout;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_addr     <= bus.base_addr;
                        r_blk_left <= bus.num_blocks;
                        r_word_cnt <= '0;
                        r_to_cnt   <= 8'd0;
                    end
                end
                S_READ: begin
                    if (w_capture) begin
                        r_block[w_slot_lsb +: 32] <= bus.sha_bram_read_data;
                        // Wraps modulo 2^32 by construction.
                        r_addr   <= r_addr + c_ADDR_STEP;
                        // Cleared here too: the last word of a block has no
                        // GAP, and the next block must start a fresh wait.
                        r_to_cnt <= 8'd0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                    r_to_cnt   <= 8'd0;
                end
                S_PRESENT: begin
                    if (w_accept) begin
                        r_blk_left <= r_blk_left - 16'd1;
                        r_word_cnt <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.busy           = (r_state != S_IDLE);
    assign bus.done           = (r_state == S_FINISH);
    assign bus.error          = r_error;
    assign bus.sha_start_read = (r_state == S_READ);
    assign bus.sha_bram_addr  = r_addr;
    assign bus.block_data     = r_block;
    assign bus.block_valid    = (r_state == S_PRESENT);
    assign bus.block_last     = (r_state == S_PRESENT) && (r_blk_left == 16'd1);

endmodule
`default_nettype wire
